// File: rtl/image_ram_mp.sv
// Multi-port image frame buffer: NP independent read/write ports with 1-cycle
// registered reads, sticky out-of-range flags and a whole-memory fill engine.
module image_ram_mp #(
  parameter int DW    = 16,
  parameter int AW    = 18,
  parameter int DEPTH = 153600,
  parameter int NP    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NP-1:0]    we,
  input  logic [NP-1:0]    re,
  input  logic [NP*AW-1:0] addr,
  input  logic [NP*DW-1:0] wd,
  output logic [NP*DW-1:0] rd,
  output logic [NP-1:0]    rd_valid,
  output logic [NP-1:0]    oob_err,
  input  logic             clear_req,
  input  logic [DW-1:0]    clear_val,
  output logic             busy,
  output logic             clear_done
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] NP_W    = (AW+1)'(NP);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                  state;
  logic [AW:0]             ptr;
  logic [DW-1:0]           fill_val;
  logic [DW-1:0]           mem [DEPTH];

  logic [NP-1:0][AW-1:0]   pa;
  logic [NP-1:0][DW-1:0]   pw;
  logic [NP-1:0][DW-1:0]   rd_q;
  logic [NP-1:0]           oob;
  logic [NP-1:0][AW:0]     fa;
  logic [NP-1:0]           fen;

  assign pa = addr;
  assign pw = wd;
  assign rd = rd_q;

  always_comb begin
    oob = '0;
    fa  = '0;
    fen = '0;
    for (int i = 0; i < NP; i++) begin
      oob[i] = {1'b0, pa[i]} >= DEPTH_W;
      fa[i]  = ptr + (AW+1)'(i);
      fen[i] = (state == FILL) && (fa[i] < DEPTH_W);
    end
  end

  // Descending loop: the last assignment wins, so the lowest-index writer
  // takes an address that several ports hit in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == FILL) begin
        for (int j = 0; j < NP; j++)
          if (fen[j]) mem[fa[j][AW-1:0]] <= fill_val;
      end else begin
        for (int i = NP-1; i >= 0; i--)
          if (we[i] && !oob[i]) mem[pa[i]] <= pw[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      rd_q       <= '0;
      rd_valid   <= '0;
      oob_err    <= '0;
    end else begin
      clear_done <= 1'b0;
      rd_valid   <= '0;
      case (state)
        IDLE: begin
          for (int i = 0; i < NP; i++) begin
            if (re[i]) begin
              rd_q[i]     <= oob[i] ? '0 : mem[pa[i]];
              rd_valid[i] <= 1'b1;
            end
            if ((re[i] || we[i]) && oob[i]) oob_err[i] <= 1'b1;
          end
          if (clear_req) begin
            state    <= FILL;
            busy     <= 1'b1;
            fill_val <= clear_val;
            ptr      <= '0;
          end
        end
        FILL: begin
          ptr <= ptr + NP_W;
          if (ptr + NP_W >= DEPTH_W) begin
            state      <= IDLE;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_image_ram_mp.sv
// Randomized bench for image_ram_mp: a flat array model with per-cycle
// read-before-write and lowest-port-wins semantics, plus directed corner steps.
module tb_image_ram_mp;
  localparam int DW = 16, AW = 18, DEPTH = 153600, NP = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    we, re;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wd;
  logic [NP*DW-1:0] rd;
  logic [NP-1:0]    rd_valid, oob_err;
  logic             clear_req;
  logic [DW-1:0]    clear_val;
  logic             busy, clear_done;

  image_ram_mp #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NP(NP)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wd(wd), .rd(rd),
    .rd_valid(rd_valid), .oob_err(oob_err), .clear_req(clear_req),
    .clear_val(clear_val), .busy(busy), .clear_done(clear_done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [DW-1:0]    mm [DEPTH];
  logic [NP*DW-1:0] exp_rd;
  logic [NP-1:0]    exp_oob;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_ports();
    we = '0; re = '0; addr = '0; wd = '0;
  endtask

  function automatic logic [AW-1:0] raddr();
    if ($urandom_range(15) == 0) return AW'($urandom_range(2**AW - 1, DEPTH));
    return AW'($urandom_range(31));
  endfunction

  task automatic rand_ports();
    for (int i = 0; i < NP; i++) begin
      we[i] = 1'($urandom_range(1));
      re[i] = 1'($urandom_range(1));
      addr[i*AW +: AW] = raddr();
      wd[i*DW +: DW] = DW'($urandom);
    end
  endtask

  // One IDLE-state cycle: predict from the model, clock, compare.
  task automatic cyc(input string tag);
    bit claimed [int];
    logic [AW-1:0] a;
    for (int i = 0; i < NP; i++) begin
      a = addr[i*AW +: AW];
      if (re[i]) exp_rd[i*DW +: DW] = (int'(a) >= DEPTH) ? '0 : mm[int'(a)];
      if ((re[i] || we[i]) && int'(a) >= DEPTH) exp_oob[i] = 1'b1;
    end
    for (int i = 0; i < NP; i++) begin
      a = addr[i*AW +: AW];
      if (we[i] && int'(a) < DEPTH && !claimed.exists(int'(a))) begin
        mm[int'(a)] = wd[i*DW +: DW];
        claimed[int'(a)] = 1'b1;
      end
    end
    tick();
    chk({tag, "_vld"}, rd_valid, re);
    chk({tag, "_rd"}, rd, exp_rd);
    chk({tag, "_oob"}, oob_err, exp_oob);
  endtask

  task automatic rd1(input string tag, input int p, input int a, input logic [DW-1:0] exp);
    idle_ports();
    re[p] = 1'b1;
    addr[p*AW +: AW] = AW'(a);
    cyc(tag);
    chk({tag, "_val"}, rd[p*DW +: DW], exp);
    idle_ports();
  endtask

  task automatic fill_wait(input string tag, input bit traffic);
    int n = 0, dn = 0;
    chk({tag, "_busy0"}, busy, 1'b1);
    while (busy === 1'b1 && n < 20000) begin
      n++;
      if (traffic) begin
        rand_ports();
        clear_req = (n < 100);
        clear_val = DW'($urandom);
      end
      tick();
      if (clear_done === 1'b1) dn++;
      chk({tag, "_busy_vld"}, rd_valid, '0);
      chk({tag, "_busy_rd"}, rd, exp_rd);
      chk({tag, "_busy_oob"}, oob_err, exp_oob);
    end
    idle_ports();
    clear_req = 1'b0;
    chk({tag, "_cycles"}, n, 15360);
    chk({tag, "_done_pulses"}, dn, 1);
    chk({tag, "_busy_end"}, busy, 1'b0);
    tick();
    chk({tag, "_done_low"}, clear_done, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] v, old;
    rst = 1'b1; clear_req = 1'b0; clear_val = '0;
    idle_ports();
    exp_rd = '0; exp_oob = '0;
    tick(); tick();
    chk("rst_rd", rd, '0);
    chk("rst_vld", rd_valid, '0);
    chk("rst_oob", oob_err, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", clear_done, 1'b0);
    rst = 1'b0;

    // Initial fill gives the whole model a defined value.
    v = DW'($urandom);
    clear_req = 1'b1; clear_val = v;
    cyc("clr0");
    clear_req = 1'b0;
    fill_wait("fill0", 1'b0);
    for (int k = 0; k < DEPTH; k++) mm[k] = v;

    // Port 0 writes, port 9 reads back the next cycle.
    idle_ports();
    we[0] = 1'b1; addr[0 +: AW] = AW'(5); wd[0 +: DW] = 16'h1234;
    cyc("w5");
    rd1("r5", 9, 5, 16'h1234);
    tick();
    chk("r5_vld_drop", rd_valid, '0);

    // Same-address write collision with a concurrent read.
    old = mm[100];
    idle_ports();
    we[2] = 1'b1; addr[2*AW +: AW] = AW'(100); wd[2*DW +: DW] = 16'hAAAA;
    we[7] = 1'b1; addr[7*AW +: AW] = AW'(100); wd[7*DW +: DW] = 16'h5555;
    re[4] = 1'b1; addr[4*AW +: AW] = AW'(100);
    cyc("coll");
    chk("coll_old", rd[4*DW +: DW], old);
    rd1("coll_win", 0, 100, 16'hAAAA);

    // Out-of-range write then read on port 3.
    idle_ports();
    we[3] = 1'b1; addr[3*AW +: AW] = AW'(DEPTH); wd[3*DW +: DW] = 16'hDEAD;
    cyc("oobw");
    chk("oobw_flag", oob_err[3], 1'b1);
    rd1("oobr", 3, DEPTH, 16'h0000);
    tick(); tick();
    chk("oob_sticky", oob_err[3], 1'b1);
    rd1("oob_nochg", 1, 0, mm[0]);

    for (int c = 0; c < 300; c++) begin
      rand_ports();
      cyc("rand");
    end

    // Fill request alongside port traffic, then traffic during busy.
    rand_ports();
    clear_req = 1'b1; clear_val = 16'h00FF;
    cyc("clr1");
    clear_req = 1'b0;
    fill_wait("fill1", 1'b1);
    for (int k = 0; k < DEPTH; k++) mm[k] = 16'h00FF;
    rd1("f1_a0", 0, 0, 16'h00FF);
    rd1("f1_a77", 5, 77, 16'h00FF);
    rd1("f1_alast", 9, DEPTH - 1, 16'h00FF);

    // Reset in fill cycle 10: addresses 0..99 filled, the rest untouched.
    idle_ports();
    for (int i = 0; i < 4; i++) begin
      we[i] = 1'b1;
      wd[i*DW +: DW] = DW'($urandom_range(16'hFFFE, 16'h0100));
    end
    addr[0*AW +: AW] = AW'(0);   wd[0*DW +: DW] = 16'hBEEF;
    addr[1*AW +: AW] = AW'(99);
    addr[2*AW +: AW] = AW'(100);
    addr[3*AW +: AW] = AW'(200); wd[3*DW +: DW] = 16'h1357;
    cyc("pre_abort");
    idle_ports();
    clear_req = 1'b1; clear_val = 16'h00FF;
    cyc("clr2");
    clear_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("abort_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", clear_done, 1'b0);
    chk("abort_vld", rd_valid, '0);
    chk("abort_oob", oob_err, '0);
    chk("abort_rd", rd, '0);
    for (int k = 0; k < 10 * NP; k++) mm[k] = 16'h00FF;
    exp_rd = '0; exp_oob = '0;
    rd1("ab_a0", 0, 0, 16'h00FF);
    rd1("ab_a99", 1, 99, 16'h00FF);
    rd1("ab_a100", 2, 100, mm[100]);
    rd1("ab_a200", 3, 200, 16'h1357);

    for (int c = 0; c < 100; c++) begin
      rand_ports();
      cyc("rand2");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/image_ram_mp.md
IMAGE_RAM_MP -- requirements
Module: image_ram_mp

Interface
REQ-001 The block SHALL have parameter DW, default 16: pixel word width in bits.
REQ-002 The block SHALL have parameter AW, default 18: address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 153600: number of words; DEPTH <= 2**AW.
REQ-004 The block SHALL have parameter NP, default 10: number of read/write ports; NP >= 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port we, input, NP bits: per-port write enable.
REQ-008 The block SHALL have port re, input, NP bits: per-port read enable.
REQ-009 The block SHALL have port addr, input, NP*AW bits: port i address in bits [i*AW +: AW].
REQ-010 The block SHALL have port wd, input, NP*DW bits: port i write data in bits [i*DW +: DW].
REQ-011 The block SHALL have port rd, output, NP*DW bits: port i registered read data.
REQ-012 The block SHALL have port rd_valid, output, NP bits: rd of port i updated this cycle.
REQ-013 The block SHALL have port oob_err, output, NP bits: sticky out-of-range address flag per port.
REQ-014 The block SHALL have port clear_req, input, 1 bit: start fill of the whole memory.
REQ-015 The block SHALL have port clear_val, input, DW bits: fill value, sampled with clear_req.
REQ-016 The block SHALL have port busy, output, 1 bit: clear engine active.
REQ-017 The block SHALL have port clear_done, output, 1 bit: one-cycle pulse when fill completes.

Function
REQ-018 Read: port i with re[i]=1 at edge N SHALL present mem[addr_i] on rd_i and pulse rd_valid[i]=1 after edge N (latency 1).
REQ-019 With re[i]=0, rd_i SHALL hold its last value and rd_valid[i] SHALL be 0.
REQ-020 Read-during-write to the same address in the same cycle SHALL return the old (pre-write) word, for any port combination.
REQ-021 Write: we[i]=1 SHALL write wd_i to mem[addr_i] at the edge; ports are independent.
REQ-022 Write collision: when several ports write the same address in one cycle, the lowest-index port SHALL win.
REQ-023 Address >= DEPTH with we or re SHALL set oob_err[i] (sticky until rst); the write SHALL be dropped and the read SHALL return 0 with rd_valid[i]=1.
REQ-024 Clear FSM states SHALL be IDLE and FILL; IDLE -> FILL on clear_req=1, latching clear_val and setting ptr=0.
REQ-025 In FILL the block SHALL write the latched value to addresses ptr .. min(ptr+NP, DEPTH)-1 each cycle, then set ptr += NP.
REQ-026 When ptr+NP >= DEPTH, the final write cycle SHALL complete, the FSM SHALL return to IDLE, and clear_done SHALL pulse for 1 cycle on the edge that leaves FILL.
REQ-027 busy SHALL be 1 exactly while in FILL; fill time SHALL be ceil(DEPTH/NP) cycles (15360 with defaults).
REQ-028 While busy, we, re and clear_req SHALL be ignored; rd_valid SHALL be 0, rd SHALL hold, and oob_err SHALL not update.
REQ-029 clear_req in the same cycle as port accesses in IDLE: the port accesses of that cycle SHALL complete, and FILL SHALL start on the next cycle.

Reset
REQ-030 While rst=1: the FSM SHALL go to IDLE with busy=0, clear_done=0, rd=0, rd_valid=0, oob_err=0, ptr=0; memory contents SHALL not be reset.
REQ-031 rst asserted mid-FILL SHALL abort the fill; addresses already written keep the fill value, and the rest keep their prior contents.
REQ-032 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-033 Port 0 writes 0x1234 to address 5; next cycle port 9 reads address 5 -> rd_9=0x1234 one cycle later, rd_valid[9]=1 for 1 cycle.
REQ-034 Ports 2 and 7 write 0xAAAA / 0x5555 to address 100 with port 4 reading it in the same cycle -> rd_4 = old value; a later read returns 0xAAAA.
REQ-035 Port 3 writes address 153600 -> oob_err[3]=1 and stays set; a read of that address returns 0; memory is unchanged.
REQ-036 clear_req with clear_val=0x00FF -> busy=1 for 15360 cycles, then clear_done pulses once; reads of addresses 0, 77 and 153599 return 0x00FF; port traffic during busy is ignored.
REQ-037 rst pulsed at fill cycle 10 -> busy=0 next cycle; address 0 reads 0x00FF; address 200 (NP=10) holds its prior value.
